// File: rtl/cnt_sched.sv
// Two-requester round-robin scheduler that grants counting windows on one shared counter.
// A granted window counts 0..length, or stops early on abort, then pulses done for one cycle.
module cnt_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_len0,
  input  logic [WIDTH-1:0] req_len1,
  output logic [1:0]       req_ready,
  input  logic             abort,
  output logic             busy,
  output logic             grant_id,
  output logic [WIDTH-1:0] cnt_value,
  output logic             done,
  output logic             done_abort
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] length;
  logic             win;
  logic             accept;
  logic             at_term;

  // On a tie the requester that did not own the previous window wins.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~grant_id;
      default: win = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && (|req_valid) && !rst;
  assign at_term = (cnt_value == length);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (abort || at_term) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    req_ready = '0;
    if (accept) req_ready = win ? 2'b10 : 2'b01;
  end

  // Abort takes precedence over the terminal compare; both hold the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_value  <= '0;
      length     <= '0;
      grant_id   <= 1'b1;
      done_abort <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id  <= win;
            length    <= win ? req_len1 : req_len0;
            cnt_value <= '0;
          end
        end
        RUN: begin
          if (abort)        done_abort <= 1'b1;
          else if (at_term) done_abort <= 1'b0;
          else              cnt_value  <= cnt_value + WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
